// File: rtl/tp_probe_sel_if.sv
// Probe-select bus: probe groups, strobes and trigger controls in; test-point bank and trigger status out.
// The driver side (master) owns the inputs; tp_probe_sel (slave) owns the outputs.
interface tp_probe_sel_if;
  logic [1:0]  PROBE_SEL;
  logic [15:0] GRP0;
  logic [15:0] GRP1;
  logic [15:0] GRP2;
  logic [15:0] GRP3;
  logic [7:0]  STB_IN;
  logic        ARM;
  logic [15:0] TRIG_MASK;
  logic [15:0] TRIG_VAL;
  logic [15:0] TP_DATA;
  logic [7:0]  TP_STB;
  logic        ARMED;
  logic        TRIGGERED;

  modport master (
    output PROBE_SEL, GRP0, GRP1, GRP2, GRP3, STB_IN, ARM, TRIG_MASK, TRIG_VAL,
    input  TP_DATA, TP_STB, ARMED, TRIGGERED
  );

  modport slave (
    input  PROBE_SEL, GRP0, GRP1, GRP2, GRP3, STB_IN, ARM, TRIG_MASK, TRIG_VAL,
    output TP_DATA, TP_STB, ARMED, TRIGGERED
  );
endinterface

// File: rtl/tp_probe_sel.sv
// Test-point probe mux (1-cycle latency) with per-bit strobe stretchers and a freeze-on-match trigger.
// Trigger FSM and hold counter exist only when TP_PROBE_TRIG_EN is defined; otherwise TP_DATA is always live.
module tp_probe_sel #(
  parameter int STRETCH     = 8,
  parameter int HOLD_CYCLES = 1024
) (
  input logic           CLK,
  input logic           RST_B,
  tp_probe_sel_if.slave bus
);

  localparam logic [3:0]  LP_STRETCH   = 4'(STRETCH);
  localparam logic [15:0] LP_HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  logic [15:0] w_sel_word;
  logic [3:0]  r_stb_cnt [8];
  logic [7:0]  w_tp_stb;
  logic [15:0] r_tp_data;

  always_comb begin
    w_sel_word = bus.GRP0;
    case (bus.PROBE_SEL)
      2'd0: w_sel_word = bus.GRP0;
      2'd1: w_sel_word = bus.GRP1;
      2'd2: w_sel_word = bus.GRP2;
      2'd3: w_sel_word = bus.GRP3;
      default: w_sel_word = bus.GRP0;
    endcase
  end

  // A strobe reloads the full length even mid-count, so back-to-back strobes never leave a gap.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int i = 0; i < 8; i++) r_stb_cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.STB_IN[i])
          r_stb_cnt[i] <= LP_STRETCH;
        else if (r_stb_cnt[i] != 4'd0)
          r_stb_cnt[i] <= r_stb_cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    w_tp_stb = 8'd0;
    for (int i = 0; i < 8; i++) w_tp_stb[i] = (r_stb_cnt[i] != 4'd0);
  end

  assign bus.TP_STB  = w_tp_stb;
  assign bus.TP_DATA = r_tp_data;

`ifdef TP_PROBE_TRIG_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HOLD} state_t;

  state_t      r_state;
  logic [15:0] r_hold_cnt;
  logic        r_armed;
  logic        r_triggered;
  logic        w_match;

  assign w_match = (((w_sel_word ^ bus.TRIG_VAL) & bus.TRIG_MASK) == 16'd0);

  // TP_DATA stays frozen through HOLD until the last hold cycle, where it reloads so output goes live on exit.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state     <= ST_IDLE;
      r_hold_cnt  <= 16'd0;
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
      r_tp_data   <= 16'd0;
    end else begin
      if (!(r_state == ST_HOLD && r_hold_cnt != 16'd0))
        r_tp_data <= w_sel_word;
      case (r_state)
        ST_IDLE: begin
          if (bus.ARM) begin
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_match) begin
            r_state     <= ST_HOLD;
            r_armed     <= 1'b0;
            r_triggered <= 1'b1;
            r_hold_cnt  <= LP_HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == 16'd0) begin
            r_state     <= ST_IDLE;
            r_triggered <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 16'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_armed     <= 1'b0;
          r_triggered <= 1'b0;
          r_hold_cnt  <= 16'd0;
        end
      endcase
    end
  end

  assign bus.ARMED     = r_armed;
  assign bus.TRIGGERED = r_triggered;
`else
  logic w_unused_trig;

  assign w_unused_trig = ^{bus.ARM, bus.TRIG_MASK, bus.TRIG_VAL};

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)
      r_tp_data <= 16'd0;
    else
      r_tp_data <= w_sel_word;
  end

  assign bus.ARMED     = 1'b0;
  assign bus.TRIGGERED = 1'b0;
`endif

endmodule

// File: tb/tb_tp_probe_sel.sv
// Directed bench for tp_probe_sel: mux latency, strobe stretch/retrigger, trigger freeze and hold, async reset abort.
// Trigger expectations follow TP_PROBE_TRIG_EN so the same bench covers both builds.
module tb_tp_probe_sel;

  logic CLK   = 1'b0;
  logic RST_B = 1'b0;

  tp_probe_sel_if bus ();

  tp_probe_sel #(
    .STRETCH     (8),
    .HOLD_CYCLES (4)
  ) dut (
    .CLK   (CLK),
    .RST_B (RST_B),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

`ifdef TP_PROBE_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] d, input logic [7:0] s,
                         input logic a, input logic t);
    chk({tag, ".data"}, bus.TP_DATA, d);
    chk({tag, ".stb"}, {8'd0, bus.TP_STB}, {8'd0, s});
    chk({tag, ".armed"}, {15'd0, bus.ARMED}, {15'd0, a});
    chk({tag, ".trig"}, {15'd0, bus.TRIGGERED}, {15'd0, t});
  endtask

  // Lands 1 time unit after the rising edge: registered outputs for the new cycle are settled.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] sel_d(input int j);
    return (j == 5 || j == 6) ? 16'h1111 : 16'hB000 + 16'(j);
  endfunction

  initial begin
    logic [15:0] exp_d;
    bus.PROBE_SEL = 2'd2;
    bus.GRP0      = 16'h0000;
    bus.GRP1      = 16'h0000;
    bus.GRP2      = 16'hA5C3;
    bus.GRP3      = 16'h0000;
    bus.STB_IN    = 8'h00;
    bus.ARM       = 1'b0;
    bus.TRIG_MASK = 16'h0000;
    bus.TRIG_VAL  = 16'h0000;

    cyc();
    cyc();
    chk_all("reset", 16'h0000, 8'h00, 1'b0, 1'b0);

    RST_B = 1'b1;
    chk("rel_no_edge", bus.TP_DATA, 16'h0000);
    cyc();
    chk("sel2", bus.TP_DATA, 16'hA5C3);
    bus.PROBE_SEL = 2'd0;
    cyc();
    chk("sel0", bus.TP_DATA, 16'h0000);
    bus.GRP1 = 16'h1234;
    bus.GRP3 = 16'hBEEF;
    bus.PROBE_SEL = 2'd1;
    cyc();
    chk("sel1", bus.TP_DATA, 16'h1234);
    bus.PROBE_SEL = 2'd3;
    cyc();
    chk("sel3", bus.TP_DATA, 16'hBEEF);
    bus.PROBE_SEL = 2'd0;
    cyc();
    chk("sel0b", bus.TP_DATA, 16'h0000);

    // Single strobe: high exactly 8 cycles.
    bus.STB_IN = 8'h08;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      bus.STB_IN = 8'h00;
      chk($sformatf("stb_single_%0d", k), {8'd0, bus.TP_STB}, (k <= 8) ? 16'h0008 : 16'h0000);
    end

    // Retrigger 4 cycles later extends to 12 cycles total.
    bus.STB_IN = 8'h08;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      bus.STB_IN = (k == 4) ? 8'h08 : 8'h00;
      chk($sformatf("stb_retrig_%0d", k), {8'd0, bus.TP_STB}, (k <= 12) ? 16'h0008 : 16'h0000);
    end

    // Independent bits: bit7 single, bit0 retriggered at k=3.
    bus.STB_IN = 8'h81;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      bus.STB_IN = (k == 3) ? 8'h01 : 8'h00;
      chk($sformatf("stb_multi_%0d", k), {8'd0, bus.TP_STB},
          {8'd0, (k <= 8) ? 1'b1 : 1'b0, 6'd0, (k <= 11) ? 1'b1 : 1'b0});
    end

    // Ramp trigger: ARM at 5, match at 66 (0x42), HOLD 67..70; ARM in ARMED (20) and HOLD (68) ignored.
    bus.PROBE_SEL = 2'd0;
    bus.TRIG_MASK = 16'h00FF;
    bus.TRIG_VAL  = 16'h0042;
    for (int k = 0; k <= 75; k++) begin
      bus.GRP0 = 16'(k);
      bus.ARM  = (k == 5 || k == 20 || k == 68);
      if (k >= 1) begin
        exp_d = (TRIG_EN && k >= 67 && k <= 70) ? 16'h0042 : 16'(k - 1);
        chk_all($sformatf("ramp_%0d", k), exp_d, 8'h00,
                TRIG_EN && k >= 6 && k <= 66, TRIG_EN && k >= 67 && k <= 70);
      end
      cyc();
    end
    bus.ARM = 1'b0;

    // Mask 0: match on the first ARMED cycle (3), hold 4..7; PROBE_SEL flips during hold are ignored.
    bus.TRIG_MASK = 16'h0000;
    bus.TRIG_VAL  = 16'hFFFF;
    bus.GRP1      = 16'h1111;
    for (int k = 0; k <= 10; k++) begin
      bus.GRP3      = 16'hB000 + 16'(k);
      bus.PROBE_SEL = (k == 5 || k == 6) ? 2'd1 : 2'd3;
      bus.ARM       = (k == 2);
      if (k >= 1) begin
        exp_d = (TRIG_EN && k >= 4 && k <= 7) ? 16'hB003 : sel_d(k - 1);
        chk_all($sformatf("mask0_%0d", k), exp_d, 8'h00,
                TRIG_EN && k == 3, TRIG_EN && k >= 4 && k <= 7);
      end
      cyc();
    end

    // Reset mid-HOLD and mid-stretch.
    bus.PROBE_SEL = 2'd0;
    bus.GRP0      = 16'h5A5A;
    bus.ARM       = 1'b1;
    bus.STB_IN    = 8'hFF;
    cyc();
    bus.ARM    = 1'b0;
    bus.STB_IN = 8'h00;
    cyc();
    chk_all("pre_rst", 16'h5A5A, 8'hFF, 1'b0, TRIG_EN);
    RST_B = 1'b0;
    #1;
    chk_all("rst_now", 16'h0000, 8'h00, 1'b0, 1'b0);
    cyc();
    chk_all("rst_held", 16'h0000, 8'h00, 1'b0, 1'b0);
    RST_B = 1'b1;
    bus.GRP0 = 16'h0101;
    chk("rst_rel", bus.TP_DATA, 16'h0000);
    cyc();
    chk_all("post_rst", 16'h0101, 8'h00, 1'b0, 1'b0);
    bus.GRP0 = 16'h0202;
    cyc();
    chk("post_rst2", bus.TP_DATA, 16'h0202);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tp_probe_sel.md
TP_PROBE_SEL -- requirements
Module: tp_probe_sel

Interface
REQ-001 Parameter STRETCH, default 8: strobe stretch length in CLK cycles; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 1024: freeze length after trigger in CLK cycles; legal range 1..65535.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  sole clock; all logic rising-edge.
REQ-005 RST_B  in  1  asynchronous active-low reset.
REQ-006 PROBE_SEL  in  2  selects probe group 0..3.
REQ-007 GRP0, GRP1, GRP2, GRP3  in  16 each  probe groups (e.g. I2C FIFO data, phase-shift status, DAQ status).
REQ-008 STB_IN  in  8  single-cycle debug strobes (e.g. I2C_WE, I2C_START, L1A).
REQ-009 ARM  in  1  single-cycle request to arm trigger.
REQ-010 TRIG_MASK  in  16  trigger bit mask; 1 = compared.
REQ-011 TRIG_VAL  in  16  trigger compare value.
REQ-012 TP_DATA  out  16  registered probe word, drives the 16-bit test-point bank.
REQ-013 TP_STB  out  8  stretched strobes, drive test-point bank strobe bits.
REQ-014 ARMED  out  1  high while trigger FSM is in ARMED.
REQ-015 TRIGGERED  out  1  high while trigger FSM is in HOLD.

Function
REQ-016 Mux output sel_word = GRP[PROBE_SEL]; TP_DATA SHALL equal sel_word of the previous cycle (latency 1) except in HOLD.
REQ-017 Each TP_STB bit SHALL have a 4-bit down-counter: STB_IN bit high at cycle n loads STRETCH; TP_STB bit high while counter nonzero.
REQ-018 Strobe at cycle n SHALL give TP_STB high in cycles n+1..n+STRETCH; a new strobe while counting SHALL reload STRETCH (no gap, extends from the last strobe).
REQ-019 Strobe stretching SHALL continue unaffected in all FSM states.
REQ-020 Trigger FSM states: IDLE, ARMED, HOLD.
REQ-021 IDLE -> ARMED on ARM=1; match SHALL NOT be evaluated in the same cycle as the ARM sample in IDLE.
REQ-022 ARMED -> HOLD when (sel_word & TRIG_MASK) == (TRIG_VAL & TRIG_MASK); ARM in ARMED ignored.
REQ-023 Match at cycle m: TP_DATA SHALL hold the matching sel_word and TRIGGERED=1 for cycles m+1..m+HOLD_CYCLES; PROBE_SEL and GRPx changes ignored for TP_DATA during HOLD.
REQ-024 16-bit hold counter SHALL load HOLD_CYCLES-1 on entry and decrement; HOLD -> IDLE when it reaches 0; at m+HOLD_CYCLES+1 TRIGGERED=0 and TP_DATA shows sel_word of cycle m+HOLD_CYCLES.
REQ-025 ARM during HOLD SHALL be ignored (no queued re-arm).
REQ-026 TRIG_MASK=0 SHALL match unconditionally: HOLD entered the first cycle after ARMED asserts.

Reset
REQ-027 RST_B low SHALL immediately force TP_DATA=0, TP_STB=0, ARMED=0, TRIGGERED=0, all counters 0, FSM IDLE.
REQ-028 Reset mid-HOLD or mid-stretch SHALL abort with no residual output; first live TP_DATA one cycle after the first clock edge with RST_B high.
REQ-029 RST_B deassertion is synchronous to CLK, guaranteed upstream.

Configuration
REQ-030 Macro TP_PROBE_TRIG_EN defined: trigger FSM, hold counter, ARMED and TRIGGERED as REQ-020..026.
REQ-031 TP_PROBE_TRIG_EN undefined: no FSM or hold counter; ARMED=0, TRIGGERED=0 constant; TP_DATA always live per REQ-016; ARM, TRIG_MASK, TRIG_VAL ignored; stretching unchanged.

Verification
REQ-032 PROBE_SEL=2, GRP2=16'hA5C3, others 0 -> TP_DATA=16'hA5C3 one cycle later; switching to 0 gives 16'h0000 next cycle.
REQ-033 STB_IN[3] pulse at cycle 10, STRETCH=8 -> TP_STB[3] high cycles 11..18 exactly; second pulse at 14 -> high 11..22.
REQ-034 ARM at cycle 5, TRIG_MASK=16'h00FF, TRIG_VAL=16'h0042, GRP0 ramps by 1 from 0 -> ARMED at 6; match when GRP0=16'h0042; TP_DATA frozen at 16'h0042, TRIGGERED high exactly HOLD_CYCLES cycles (HOLD_CYCLES=4 in test), then live.
REQ-035 ARM pulsed during HOLD and during ARMED -> no extra trigger; FSM IDLE after hold with ARMED=0.
REQ-036 RST_B low mid-HOLD and mid-stretch -> all outputs 0 same cycle; after release TP_DATA tracks GRP0 with 1-cycle latency.
REQ-037 Build without TP_PROBE_TRIG_EN, repeat REQ-034 stimulus -> ARMED=TRIGGERED=0 throughout, TP_DATA never frozen.
